adder_pipe: RTL and testbench
=============================

# adder_pipe

Parametrised, elastic, pipelined add/subtract unit; the next generation of the single-op `adder`. Operands enter on a valid/ready handshake and leave after a configurable number of register stages with full backpressure. The result carries carry/borrow and signed-overflow flags, and a running count of delivered results. It sits between an operand source and a result consumer in the datapath and is driven by the class-based bench through `tb_intf`.

## Interface
- `WIDTH`, 8, operand/result width in bits (2..32)
- `STAGES`, 2, pipeline register stages = no-stall latency in cycles (1..8)
- `clk`  input  1  rising-edge clock; the only clock
- `rst`  input  1  asynchronous, active-high reset
- `valid_in`  input  1  operand beat valid
- `ready_in`  output  1  unit accepts a beat this cycle
- `a`  input  WIDTH  operand A
- `b`  input  WIDTH  operand B
- `op`  input  1  0 = A+B, 1 = A−B
- `valid_out`  output  1  result beat valid
- `ready_out`  input  1  consumer accepts result
- `result`  output  WIDTH  sum/difference
- `carry_out`  output  1  add: carry out of MSB; sub: 1 when A ≥ B unsigned (no borrow)
- `overflow`  output  1  signed two's-complement overflow of this beat
- `txn_count`  output  16  results delivered since reset

## Operation
- Stage k holds `vld[k]`, data and flags. `adv[STAGES-1] = ready_out | ~vld[STAGES-1]`. `adv[k] = adv[k+1] | ~vld[k]`.
- `ready_in = adv[0]` is combinational and does not depend on `valid_in`.
- Accept occurs when `valid_in & ready_in`. Arithmetic is computed combinationally from `a`, `b` and `op`, then registered into stage 0. Later stages pass data unchanged.
- A stage register loads only when its `adv` is high. Otherwise it holds, so payload is stable while `valid_out & ~ready_out`.
- Add: `{carry, sum} = a + b`, computed at WIDTH+1 bits.
- Sub: `{carry, diff} = a + ~b + 1`, computed at WIDTH+1 bits.
- Add overflow: `a[MSB] == b[MSB]` and `res[MSB] != a[MSB]`.
- Sub overflow: `a[MSB] != b[MSB]` and `res[MSB] != a[MSB]`.
- `valid_out = vld[STAGES-1]`. `result`, `carry_out` and `overflow` come from the last stage.
- When `valid_out` is low, the last delivered payload is held. Benches must not check it.
- `txn_count` increments on `valid_out & ready_out` and wraps 0xFFFF→0x0000.
- Ordering is strictly FIFO. No beat is dropped or duplicated.
- Maximum occupancy is STAGES beats.

## Timing
- Reset (async assert, sync release on the next edge):
  - all `vld` = 0, so `valid_out` = 0 immediately
  - `result`, `carry_out`, `overflow` = 0
  - `txn_count` = 0
  - `ready_in` = 1 (pipeline empty)
- No-stall latency: a beat accepted at edge N shows `valid_out` = 1 after edge N+STAGES−1. That is STAGES cycles from the accept cycle.
- Throughput is one beat per cycle while `ready_out` stays high.
- Stall:
  - When `ready_out` = 0, bubbles collapse first.
  - `ready_in` falls only when every stage is valid and `ready_out` = 0.
- Simultaneous accept and deliver in the same cycle with a full pipe is legal. Occupancy is unchanged and `ready_in` = 1 that cycle if `ready_out` = 1.
- Reset asserted mid-operation discards all in-flight beats with no partial outputs. Inputs are ignored while `rst` = 1.

## Configuration
- `ADDER_SATURATE_EN` defined:
  - when `overflow` = 1, stage 0 stores the clamped value instead of the wrapped one
  - the clamp is signed max (0x7F for WIDTH=8) when the true result is positive, signed min (0x80) when negative
  - `overflow` is still reported; `carry_out` is unchanged
- Undefined: the result wraps modulo 2^WIDTH. No clamp logic is synthesised.

## Test plan
- Reset: assert `rst` between edges with `valid_in` = 1 → `valid_out` = 0, `result` = 0, `txn_count` = 0, `ready_in` = 1 with no clock needed.
- Add, WIDTH=8, STAGES=2:
  - 100+27 → 127, carry 0, ovf 0, two cycles after accept.
  - 100+28 → 0x80, ovf 1 (0x7F with `ADDER_SATURATE_EN`).
  - 0xFF+0x01 → 0x00, carry 1, ovf 0.
- Sub:
  - 5−10 → 0xFB, carry 0, ovf 0.
  - 0x80−0x01 → 0x7F, ovf 1 (0x80 saturated).
  - 10−10 → 0x00, carry 1.
- Backpressure: stream 10 random beats and hold `ready_out` = 0 for 5 cycles mid-stream → `ready_in` drops once STAGES beats are held, all 10 results arrive in order against the scoreboard, `txn_count` = 10.
- Throughput: `valid_in` = `ready_out` = 1 for 20 cycles, STAGES=4 → first result at cycle 4, then one per cycle, `txn_count` = 20 after 23 cycles.
- Reset mid-stream: assert `rst` with 3 beats in flight → `valid_out` drops immediately, none of the 3 appear after release, `txn_count` = 0.

Source files
------------

// File: rtl/adder_pipe_if.sv
// adder_pipe_if: operand-in / result-out handshake bundle for adder_pipe.
// The master side is the operand source and result consumer; the slave side is the adder.
interface adder_pipe_if #(
  parameter int WIDTH = 8
) ();
  logic             valid_in;
  logic             ready_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op;
  logic             valid_out;
  logic             ready_out;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic [15:0]      txn_count;

  modport master (
    output valid_in, a, b, op, ready_out,
    input  ready_in, valid_out, result, carry_out, overflow, txn_count
  );

  modport slave (
    input  valid_in, a, b, op, ready_out,
    output ready_in, valid_out, result, carry_out, overflow, txn_count
  );
endinterface

// File: rtl/adder_pipe.sv
// adder_pipe: elastic STAGES-deep add/subtract pipeline with carry/overflow flags and a delivered-beat counter.
// Define ADDER_SATURATE_EN to clamp overflowing results to the signed limit instead of wrapping.
module adder_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  adder_pipe_if.slave bus
);
  localparam int MSB = WIDTH - 1;

  function automatic logic ovf_detect(input logic a_msb, input logic b_msb,
                                      input logic r_msb, input logic sub);
    if (sub) return (a_msb != b_msb) && (r_msb != a_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

`ifdef ADDER_SATURATE_EN
  // On overflow the true result has the sign of operand A, so A's MSB picks the limit.
  function automatic logic signed [WIDTH-1:0] sat_clamp(input logic signed [WIDTH-1:0] wrapped,
                                                        input logic ovf, input logic true_neg);
    if (!ovf) return wrapped;
    if (true_neg) return {1'b1, {(WIDTH-1){1'b0}}};
    return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  logic [WIDTH:0]          sum_p0;
  logic [WIDTH-1:0]        b_eff_p0;
  logic signed [WIDTH-1:0] res_p0;
  logic                    cy_p0;
  logic                    ovf_p0;

  logic [STAGES-1:0]       adv;
  logic [STAGES-1:0]       vld_d, vld_q;
  logic signed [WIDTH-1:0] res_d [STAGES];
  logic signed [WIDTH-1:0] res_q [STAGES];
  logic [STAGES-1:0]       cy_d, cy_q;
  logic [STAGES-1:0]       ovf_d, ovf_q;
  logic [15:0]             cnt_d, cnt_q;
  logic                    accept;
  logic                    deliver;

  // ---- stage 0 input: arithmetic computed straight from the operand bus ----
  always_comb begin
    b_eff_p0 = bus.op ? ~bus.b : bus.b;
    sum_p0   = {1'b0, bus.a} + {1'b0, b_eff_p0} + {{WIDTH{1'b0}}, bus.op};
    cy_p0    = sum_p0[WIDTH];
    ovf_p0   = ovf_detect(bus.a[MSB], bus.b[MSB], sum_p0[MSB], bus.op);
`ifdef ADDER_SATURATE_EN
    res_p0   = sat_clamp(sum_p0[MSB:0], ovf_p0, bus.a[MSB]);
`else
    res_p0   = sum_p0[MSB:0];
`endif
  end

  // A stage may advance when its successor advances or it holds a bubble.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = bus.ready_out | ~vld_q[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = adv[k+1] | ~vld_q[k];
    end
  end

  assign accept  = bus.valid_in & adv[0];
  assign deliver = vld_q[STAGES-1] & bus.ready_out;

  // ---- stage registers: payload only moves with a valid beat, so it holds otherwise ----
  always_comb begin
    vld_d = vld_q;
    res_d = res_q;
    cy_d  = cy_q;
    ovf_d = ovf_q;
    if (adv[0]) begin
      vld_d[0] = accept;
      if (accept) begin
        res_d[0] = res_p0;
        cy_d[0]  = cy_p0;
        ovf_d[0] = ovf_p0;
      end
    end
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          res_d[k] = res_q[k-1];
          cy_d[k]  = cy_q[k-1];
          ovf_d[k] = ovf_q[k-1];
        end
      end
    end
    cnt_d = cnt_q + {15'd0, deliver};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      cy_q  <= '0;
      ovf_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < STAGES; k++) res_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
      cy_q  <= cy_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  // ---- last stage drives the result bus ----
  assign bus.ready_in  = adv[0];
  assign bus.valid_out = vld_q[STAGES-1];
  assign bus.result    = res_q[STAGES-1];
  assign bus.carry_out = cy_q[STAGES-1];
  assign bus.overflow  = ovf_q[STAGES-1];
  assign bus.txn_count = cnt_q;
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed-vector bench for adder_pipe, using a STAGES=2 and a STAGES=4 instance.
// Honours ADDER_SATURATE_EN for the expected overflow results.
module tb_adder_pipe;
  localparam int W = 8;

`ifdef ADDER_SATURATE_EN
  localparam logic [7:0] OVF_ADD_RES = 8'h7F;
  localparam logic [7:0] OVF_SUB_RES = 8'h80;
`else
  localparam logic [7:0] OVF_ADD_RES = 8'h80;
  localparam logic [7:0] OVF_SUB_RES = 8'h7F;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  // Hand-computed backpressure vectors (none overflow).
  logic [7:0] va [10] = '{8'd1, 8'd10, 8'd200, 8'd50, 8'd7, 8'h30, 8'd255, 8'd20, 8'd3, 8'd9};
  logic [7:0] vb [10] = '{8'd2, 8'd3, 8'd100, 8'd60, 8'd8, 8'h10, 8'd1, 8'd30, 8'd4, 8'd9};
  logic       vop[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] ve [10] = '{8'd3, 8'd7, 8'h2C, 8'hF6, 8'd15, 8'h40, 8'd254, 8'd50, 8'hFF, 8'd18};

  always #5 clk = ~clk;

  adder_pipe_if #(.WIDTH(W)) bi2 ();
  adder_pipe_if #(.WIDTH(W)) bi4 ();

  adder_pipe #(.WIDTH(W), .STAGES(2)) dut2 (.clk(clk), .rst(rst), .bus(bi2.slave));
  adder_pipe #(.WIDTH(W), .STAGES(4)) dut4 (.clk(clk), .rst(rst), .bus(bi4.slave));

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bi2.valid_in = 1'b1; bi2.a = 8'h11; bi2.b = 8'h22; bi2.op = 1'b0; bi2.ready_out = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    n_cmp++;
    if (bi2.txn_count !== 16'd2) begin
      n_err++; $display("FAIL pre_reset_txn: got %0d want 2", bi2.txn_count);
    end
    n_cmp++;
    if (bi2.result !== 8'h33) begin
      n_err++; $display("FAIL pre_reset_res: got %0h want 33", bi2.result);
    end
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (bi2.valid_out !== 1'b0) begin
      n_err++; $display("FAIL reset_vout: got %0b want 0", bi2.valid_out);
    end
    n_cmp++;
    if (bi2.result !== 8'h00) begin
      n_err++; $display("FAIL reset_res: got %0h want 0", bi2.result);
    end
    n_cmp++;
    if (bi2.txn_count !== 16'd0) begin
      n_err++; $display("FAIL reset_txn: got %0d want 0", bi2.txn_count);
    end
    n_cmp++;
    if (bi2.ready_in !== 1'b1) begin
      n_err++; $display("FAIL reset_rdy: got %0b want 1", bi2.ready_in);
    end
    n_cmp++;
    if ({bi2.carry_out, bi2.overflow} !== 2'b00) begin
      n_err++; $display("FAIL reset_flags: got %0b want 00", {bi2.carry_out, bi2.overflow});
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bi2.valid_out !== 1'b0) begin
      n_err++; $display("FAIL reset_ignore_in: got %0b want 0", bi2.valid_out);
    end
    bi2.valid_in = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic iop,
                       input logic [7:0] er, input logic ec, input logic eo, input string nm);
    bi2.valid_in = 1'b1; bi2.a = ia; bi2.b = ib; bi2.op = iop; bi2.ready_out = 1'b1;
    @(posedge clk); #1;
    bi2.valid_in = 1'b0;
    n_cmp++;
    if (bi2.valid_out !== 1'b0) begin
      n_err++; $display("FAIL %s_early: valid_out got %0b want 0", nm, bi2.valid_out);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bi2.valid_out !== 1'b1) begin
      n_err++; $display("FAIL %s_lat: valid_out got %0b want 1", nm, bi2.valid_out);
    end
    n_cmp++;
    if (bi2.result !== er) begin
      n_err++; $display("FAIL %s_res: got %0h want %0h", nm, bi2.result, er);
    end
    n_cmp++;
    if (bi2.carry_out !== ec) begin
      n_err++; $display("FAIL %s_carry: got %0b want %0b", nm, bi2.carry_out, ec);
    end
    n_cmp++;
    if (bi2.overflow !== eo) begin
      n_err++; $display("FAIL %s_ovf: got %0b want %0b", nm, bi2.overflow, eo);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    do_op(8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0, "add_127");
    do_op(8'd100, 8'd28, 1'b0, OVF_ADD_RES, 1'b0, 1'b1, "add_ovf");
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_carry");
  endtask

  task automatic test_sub();
    do_op(8'd5, 8'd10, 1'b1, 8'hFB, 1'b0, 1'b0, "sub_neg");
    do_op(8'h80, 8'h01, 1'b1, OVF_SUB_RES, 1'b1, 1'b1, "sub_ovf");
    do_op(8'd10, 8'd10, 1'b1, 8'h00, 1'b1, 1'b0, "sub_zero");
    n_cmp++;
    if (bi2.txn_count !== 16'd6) begin
      n_err++; $display("FAIL ops_txn: got %0d want 6", bi2.txn_count);
    end
  endtask

  task automatic test_backpressure();
    int   sent = 0;
    int   got  = 0;
    int   cyc  = 0;
    int   occ;
    bit   dropped = 1'b0;
    logic exp_rdy;
    apply_reset();
    while (got < 10 && cyc < 100) begin
      bi2.ready_out = !(cyc >= 3 && cyc < 8);
      bi2.valid_in  = (sent < 10);
      if (sent < 10) begin
        bi2.a = va[sent]; bi2.b = vb[sent]; bi2.op = vop[sent];
      end
      #1;
      occ = sent - got;
      exp_rdy = !(occ == 2 && !bi2.ready_out);
      n_cmp++;
      if (bi2.ready_in !== exp_rdy) begin
        n_err++; $display("FAIL bp_ready cyc%0d: got %0b want %0b", cyc, bi2.ready_in, exp_rdy);
      end
      if (bi2.ready_in === 1'b0) dropped = 1'b1;
      if (bi2.valid_out && bi2.ready_out) begin
        n_cmp++;
        if (bi2.result !== ve[got]) begin
          n_err++; $display("FAIL bp_res beat%0d: got %0h want %0h", got, bi2.result, ve[got]);
        end
        got++;
      end
      if (bi2.valid_in && bi2.ready_in) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    bi2.valid_in = 1'b0; bi2.ready_out = 1'b1;
    n_cmp++;
    if (got != 10) begin
      n_err++; $display("FAIL bp_timeout: got %0d beats want 10", got);
    end
    n_cmp++;
    if (!dropped) begin
      n_err++; $display("FAIL bp_drop: ready_in low seen %0b want 1", dropped);
    end
    n_cmp++;
    if (bi2.txn_count !== 16'd10) begin
      n_err++; $display("FAIL bp_txn: got %0d want 10", bi2.txn_count);
    end
  endtask

  task automatic test_throughput();
    logic [7:0]  exp_r;
    logic [15:0] exp_c;
    apply_reset();
    bi4.valid_in = 1'b1; bi4.a = 8'd0; bi4.b = 8'd1; bi4.op = 1'b0; bi4.ready_out = 1'b1;
    for (int k = 0; k <= 23; k++) begin
      @(posedge clk); #1;
      exp_c = (k >= 3) ? 16'(k - 3) : 16'd0;
      if (k < 3 || k == 23) begin
        n_cmp++;
        if (bi4.valid_out !== 1'b0) begin
          n_err++; $display("FAIL tp_vout k%0d: got %0b want 0", k, bi4.valid_out);
        end
      end else begin
        exp_r = 8'(k - 2);
        n_cmp++;
        if (bi4.valid_out !== 1'b1 || bi4.result !== exp_r) begin
          n_err++; $display("FAIL tp_res k%0d: got v%0b %0h want v1 %0h", k, bi4.valid_out, bi4.result, exp_r);
        end
      end
      n_cmp++;
      if (bi4.txn_count !== exp_c) begin
        n_err++; $display("FAIL tp_txn k%0d: got %0d want %0d", k, bi4.txn_count, exp_c);
      end
      n_cmp++;
      if (bi4.ready_in !== 1'b1) begin
        n_err++; $display("FAIL tp_ready k%0d: got %0b want 1", k, bi4.ready_in);
      end
      if (k + 1 < 20) bi4.a = 8'(k + 1);
      else bi4.valid_in = 1'b0;
    end
  endtask

  task automatic test_reset_midstream();
    bi4.ready_out = 1'b0; bi4.b = 8'd0; bi4.op = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bi4.valid_in = 1'b1; bi4.a = 8'(i);
      @(posedge clk); #1;
    end
    bi4.valid_in = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (bi4.valid_out !== 1'b1 || bi4.txn_count !== 16'd20) begin
      n_err++; $display("FAIL mid_pre: got v%0b txn%0d want v1 txn20", bi4.valid_out, bi4.txn_count);
    end
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (bi4.valid_out !== 1'b0) begin
      n_err++; $display("FAIL mid_vout: got %0b want 0", bi4.valid_out);
    end
    n_cmp++;
    if (bi4.txn_count !== 16'd0 || bi4.ready_in !== 1'b1) begin
      n_err++; $display("FAIL mid_state: got txn%0d rdy%0b want txn0 rdy1", bi4.txn_count, bi4.ready_in);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bi4.ready_out = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bi4.valid_out !== 1'b0) begin
        n_err++; $display("FAIL mid_ghost k%0d: valid_out got %0b want 0", k, bi4.valid_out);
      end
    end
    n_cmp++;
    if (bi4.txn_count !== 16'd0) begin
      n_err++; $display("FAIL mid_txn: got %0d want 0", bi4.txn_count);
    end
  endtask

  initial begin
    bi2.valid_in = 1'b0; bi2.a = '0; bi2.b = '0; bi2.op = 1'b0; bi2.ready_out = 1'b1;
    bi4.valid_in = 1'b0; bi4.a = '0; bi4.b = '0; bi4.op = 1'b0; bi4.ready_out = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_throughput();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
